// File: rtl/vc_port_controller.sv
// ----------------------------------------------------------------------------
// vc_port_controller
//
// Input-port control for a virtual-channel router. One instance sits at each
// router input port. It:
//   * demultiplexes incoming flits onto the external per-VC FIFOs (push only;
//     the flit data goes straight from upstream into the FIFO),
//   * runs one packet FSM per VC (IDLE -> REQ -> ACTIVE) that requests an
//     output port from the switch allocator and holds it for the packet,
//   * drops orphan body/tail flits that reach an idle VC and counts them,
//   * round-robin multiplexes the granted VCs onto the single crossbar input.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   in_valid/in_vc    upstream flit valid and its VC
//   in_ready          upstream ready (selected VC FIFO not full)
//   buf_push/buf_pop  per-VC FIFO push / pop strobes
//   buf_full/empty    per-VC FIFO status
//   buf_head_data     per-VC FIFO head words, VC v at [v*DATA_WIDTH +: DATA_WIDTH]
//   route_req_valid   per-VC route request valid (VC in REQ)
//   route_req         per-VC requested output port, latched from the head flit
//   route_grant       per-VC grant pulse from the switch allocator
//   route_release     per-VC one-cycle release pulse after a packet's last pop
//   out_valid/ready   crossbar-side handshake
//   out_vc/out_data   selected VC and its head word
//   err_count         saturating count of dropped orphan flits
//
// Flit type lives in data[DATA_WIDTH-1 -: TYPE_WIDTH]:
//   00 single (head+tail), 01 head, 10 body, 11 tail.
// ----------------------------------------------------------------------------
module vc_port_controller #(
  parameter int VC            = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int TYPE_WIDTH    = 2,
  parameter int REQUEST_WIDTH = 2,
  parameter int VCW           = $clog2(VC),
  parameter int ERR_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic                          in_valid,
  input  logic [VCW-1:0]                in_vc,
  output logic                          in_ready,

  output logic [VC-1:0]                 buf_push,
  input  logic [VC-1:0]                 buf_full,
  input  logic [VC-1:0]                 buf_empty,
  input  logic [VC*DATA_WIDTH-1:0]      buf_head_data,
  output logic [VC-1:0]                 buf_pop,

  output logic [VC-1:0]                 route_req_valid,
  output logic [VC*REQUEST_WIDTH-1:0]   route_req,
  input  logic [VC-1:0]                 route_grant,
  output logic [VC-1:0]                 route_release,

  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [VCW-1:0]                out_vc,
  output logic [DATA_WIDTH-1:0]         out_data,

  output logic [ERR_WIDTH-1:0]          err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } vc_state_e;

  localparam logic [TYPE_WIDTH-1:0] TYPE_SINGLE = TYPE_WIDTH'(0);
  localparam logic [TYPE_WIDTH-1:0] TYPE_HEAD   = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] TYPE_TAIL   = TYPE_WIDTH'(3);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  vc_state_e                  state_q [VC];
  vc_state_e                  state_d [VC];
  logic [REQUEST_WIDTH-1:0]   req_q   [VC];
  logic [REQUEST_WIDTH-1:0]   req_d   [VC];
  logic [VC-1:0]              release_q, release_d;
  logic [VCW-1:0]             rr_q, rr_d;
  logic [ERR_WIDTH-1:0]       err_q, err_d;

  // --------------------------------------------------------------------------
  // Head-flit decode and per-VC qualifiers
  // --------------------------------------------------------------------------
  logic [TYPE_WIDTH-1:0]      head_type     [VC];
  logic [REQUEST_WIDTH-1:0]   head_req      [VC];
  logic [VC-1:0]              head_is_start;  // single or head: opens a packet
  logic [VC-1:0]              head_is_end;    // single or tail: closes a packet
  logic [VC-1:0]              drop;           // orphan at the front of an idle VC
  logic [VC-1:0]              eligible;       // active VC with a flit to send
  logic [VC-1:0]              out_pop;        // pop caused by the output handshake

  // NOTE: every signal assigned in an always_comb gets a default before any
  // conditional assignment, so no path leaves it holding an old value (latch).
  always_comb begin
    head_is_start = '0;
    head_is_end   = '0;
    drop          = '0;
    eligible      = '0;
    for (int v = 0; v < VC; v++) begin
      head_type[v]     = buf_head_data[v*DATA_WIDTH + DATA_WIDTH - 1 -: TYPE_WIDTH];
      head_req[v]      = buf_head_data[v*DATA_WIDTH +: REQUEST_WIDTH];
      head_is_start[v] = (head_type[v] == TYPE_SINGLE) || (head_type[v] == TYPE_HEAD);
      head_is_end[v]   = (head_type[v] == TYPE_SINGLE) || (head_type[v] == TYPE_TAIL);
      // Drops are gated by reset so buf_pop stays low while the block is held.
      drop[v]          = rst && (state_q[v] == ST_IDLE) && !buf_empty[v] && !head_is_start[v];
      eligible[v]      = (state_q[v] == ST_ACTIVE) && !buf_empty[v];
    end
  end

  // --------------------------------------------------------------------------
  // Input demux
  // --------------------------------------------------------------------------
  // Walking the VCs instead of indexing with in_vc keeps an out-of-range VC
  // number (non-power-of-two VC counts) from addressing a missing FIFO.
  always_comb begin
    in_ready = 1'b0;
    buf_push = '0;
    for (int v = 0; v < VC; v++) begin
      if (in_vc == VCW'(v)) begin
        in_ready    = !buf_full[v];
        buf_push[v] = in_valid && !buf_full[v];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin output arbiter
  // --------------------------------------------------------------------------
  // Search starts at rr_q and wraps; the first eligible VC wins. rr_q only
  // moves on a completed handshake, so the choice is stable under backpressure.
  logic           found;
  logic [VCW-1:0] sel;
  logic           out_fire;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < VC; i++) begin
      if (!found && eligible[(int'(rr_q) + i) % VC]) begin
        found = 1'b1;
        sel   = VCW'((int'(rr_q) + i) % VC);
      end
    end
  end

  assign out_valid = found;
  assign out_vc    = sel;
  assign out_data  = buf_head_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    out_pop = '0;
    for (int v = 0; v < VC; v++) begin
      out_pop[v] = out_fire && (sel == VCW'(v));
    end
  end

  // An idle VC can only drop and an active VC can only send, so the two pop
  // sources never hit the same VC in one cycle.
  assign buf_pop = drop | out_pop;

  always_comb begin
    rr_d = rr_q;
    if (out_fire) begin
      rr_d = VCW'((int'(sel) + 1) % VC);
    end
  end

  // --------------------------------------------------------------------------
  // Per-VC packet FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    release_d = '0;
    err_d     = err_q;
    for (int v = 0; v < VC; v++) begin
      state_d[v] = state_q[v];
      req_d[v]   = req_q[v];
      unique case (state_q[v])
        ST_IDLE: begin
          if (!buf_empty[v]) begin
            if (head_is_start[v]) begin
              state_d[v] = ST_REQ;
              req_d[v]   = head_req[v];
            end else if (drop[v] && (err_d != '1)) begin
              // Several VCs may drop in the same cycle; each one counts.
              err_d = err_d + ERR_WIDTH'(1);
            end
          end
        end
        ST_REQ: begin
          if (route_grant[v]) begin
            state_d[v] = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // Any flit popped here is treated as part of the packet; only the
          // closing flit types end it.
          if (out_pop[v] && head_is_end[v]) begin
            state_d[v]   = ST_IDLE;
            release_d[v] = 1'b1;
          end
        end
        default: begin
          state_d[v] = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  // NOTE: the latched request array is only VC entries wide and must read as
  // zero after reset, so it is reset like any other register rather than being
  // left to power-up contents the way a storage RAM would be.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC; v++) begin
        state_q[v] <= ST_IDLE;
        req_q[v]   <= '0;
      end
      release_q <= '0;
      rr_q      <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      release_q <= release_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs derived from state
  // --------------------------------------------------------------------------
  always_comb begin
    route_req_valid = '0;
    route_req       = '0;
    for (int v = 0; v < VC; v++) begin
      route_req_valid[v]                        = (state_q[v] == ST_REQ);
      route_req[v*REQUEST_WIDTH +: REQUEST_WIDTH] = req_q[v];
    end
  end

  // The release pulse is registered: it appears the cycle after the last pop.
  assign route_release = release_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_vc_port_controller.sv
// ----------------------------------------------------------------------------
// tb_vc_port_controller
//
// The bench owns the per-VC FIFOs (queues of flit words, depth 4) and the
// upstream packet sources. A behavioural model tracks, for each VC, whether it
// is idle, waiting for a grant or sending, plus the latched request, pending
// release pulse, round-robin pointer and drop count. cycle() compares every
// DUT output against that model each clock, then advances FIFOs and model.
// Directed sequences add hand-computed literal expectations on top.
// ----------------------------------------------------------------------------
module tb_vc_port_controller;

  localparam int VC    = 4;
  localparam int DW    = 32;
  localparam int TW    = 2;
  localparam int RW    = 2;
  localparam int VCW   = 2;
  localparam int EW    = 8;
  localparam int DEPTH = 4;
  localparam int ERR_MAX = (1 << EW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_SEND = 2;

  localparam logic [1:0] T_SINGLE = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_BODY   = 2'b10;
  localparam logic [1:0] T_TAIL   = 2'b11;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [VCW-1:0]       in_vc;
  logic                 in_ready;
  logic [VC-1:0]        buf_push, buf_full, buf_empty, buf_pop;
  logic [VC*DW-1:0]     buf_head_data;
  logic [VC-1:0]        route_req_valid, route_grant, route_release;
  logic [VC*RW-1:0]     route_req;
  logic                 out_valid, out_ready;
  logic [VCW-1:0]       out_vc;
  logic [DW-1:0]        out_data;
  logic [EW-1:0]        err_count;

  logic [DW-1:0]        in_data;   // word the bench FIFO stores on a push

  vc_port_controller #(
    .VC(VC), .DATA_WIDTH(DW), .TYPE_WIDTH(TW), .REQUEST_WIDTH(RW),
    .VCW(VCW), .ERR_WIDTH(EW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_vc(in_vc), .in_ready(in_ready),
    .buf_push(buf_push), .buf_full(buf_full), .buf_empty(buf_empty),
    .buf_head_data(buf_head_data), .buf_pop(buf_pop),
    .route_req_valid(route_req_valid), .route_req(route_req),
    .route_grant(route_grant), .route_release(route_release),
    .out_valid(out_valid), .out_ready(out_ready), .out_vc(out_vc),
    .out_data(out_data), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Environment and model state
  logic [DW-1:0] fifo [VC][$];
  logic [DW-1:0] src  [VC][$];
  int            m_mode [VC];
  int            m_req  [VC];
  bit            m_rel  [VC];
  int            m_rr;
  int            m_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  // Observations from the most recent cycle, for directed literal checks
  logic            last_ov;
  logic [VCW-1:0]  last_vc;
  logic [DW-1:0]   last_data;
  logic [VC-1:0]   last_pop, last_push, last_rqv, last_rel;
  logic [VC*RW-1:0] last_req;
  logic [EW-1:0]   last_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int req);
    logic [DW-1:0] d;
    d = $urandom;
    d[DW-1 -: TW] = t;
    d[RW-1:0]     = RW'(req);
    return d;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < VC; v++) begin
      m_mode[v] = M_IDLE;
      m_req[v]  = 0;
      m_rel[v]  = 1'b0;
    end
    m_rr  = 0;
    m_err = 0;
  endtask

  task automatic drive_fifo_outputs();
    for (int v = 0; v < VC; v++) begin
      buf_empty[v] = (fifo[v].size() == 0);
      buf_full[v]  = (fifo[v].size() >= DEPTH);
      buf_head_data[v*DW +: DW] = (fifo[v].size() == 0) ? '0 : fifo[v][0];
    end
  endtask

  // One clock: present FIFO state, compare all outputs, advance everything.
  // Called just after a falling edge with the inputs already set.
  task automatic cycle();
    logic [VC-1:0]    e_push, e_pop, e_rqv, e_rel, drop, rel_n, a_push, a_pop;
    logic [VC*RW-1:0] e_req;
    logic             e_in_ready, e_ov, hs;
    logic [1:0]       ht;
    logic [DW-1:0]    a_data;
    int               sel;

    if (!rst) model_reset();
    drive_fifo_outputs();
    #2;

    e_in_ready = (fifo[in_vc].size() < DEPTH);
    e_push = '0;
    if (in_valid && e_in_ready) e_push[in_vc] = 1'b1;

    sel = -1;
    for (int i = 0; i < VC; i++) begin
      if (sel < 0 && m_mode[(m_rr + i) % VC] == M_SEND && fifo[(m_rr + i) % VC].size() > 0)
        sel = (m_rr + i) % VC;
    end
    e_ov = (sel >= 0);
    hs   = e_ov && out_ready;

    drop = '0; e_rqv = '0; e_rel = '0; e_req = '0;
    for (int v = 0; v < VC; v++) begin
      // Body and tail both have the top type bit set.
      if (rst && m_mode[v] == M_IDLE && fifo[v].size() > 0 && fifo[v][0][DW-1]) drop[v] = 1'b1;
      e_rqv[v] = (m_mode[v] == M_WAIT);
      e_rel[v] = m_rel[v];
      e_req[v*RW +: RW] = RW'(m_req[v]);
    end
    e_pop = drop;
    if (hs) e_pop[sel] = 1'b1;

    check("in_ready", in_ready, e_in_ready);
    check("buf_push", buf_push, e_push);
    check("buf_pop", buf_pop, e_pop);
    check("route_req_valid", route_req_valid, e_rqv);
    check("route_req", route_req, e_req);
    check("route_release", route_release, e_rel);
    check("out_valid", out_valid, e_ov);
    if (e_ov) begin
      check("out_vc", out_vc, sel);
      check("out_data", out_data, fifo[sel][0]);
    end
    check("err_count", err_count, m_err);

    last_ov = out_valid; last_vc = out_vc; last_data = out_data;
    last_pop = buf_pop; last_push = buf_push; last_rqv = route_req_valid;
    last_rel = route_release; last_req = route_req; last_err = err_count;
    if (hs) n_out++;

    a_push = buf_push; a_pop = buf_pop; a_data = in_data;

    if (rst) begin
      rel_n = '0;
      for (int v = 0; v < VC; v++) begin
        case (m_mode[v])
          M_IDLE: if (fifo[v].size() > 0) begin
            ht = fifo[v][0][DW-1 -: 2];
            if (ht == T_SINGLE || ht == T_HEAD) begin
              m_mode[v] = M_WAIT;
              m_req[v]  = int'(fifo[v][0][RW-1:0]);
            end else if (m_err < ERR_MAX) begin
              m_err++;
            end
          end
          M_WAIT: if (route_grant[v]) m_mode[v] = M_SEND;
          default: if (hs && sel == v) begin
            ht = fifo[v][0][DW-1 -: 2];
            if (ht == T_TAIL || ht == T_SINGLE) begin
              m_mode[v] = M_IDLE;
              rel_n[v]  = 1'b1;
            end
          end
        endcase
      end
      for (int v = 0; v < VC; v++) m_rel[v] = rel_n[v];
      if (hs) m_rr = (sel + 1) % VC;
    end

    @(posedge clk);
    for (int v = 0; v < VC; v++) begin
      if (a_pop[v] && fifo[v].size() > 0) void'(fifo[v].pop_front());
      if (a_push[v] && fifo[v].size() < DEPTH) fifo[v].push_back(a_data);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_vc = '0; in_data = '0;
    route_grant = '0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    for (int v = 0; v < VC; v++) begin
      fifo[v].delete();
      src[v].delete();
    end
    cycle();
    cycle();
    rst = 1'b1;
  endtask

  task automatic push(input int v, input logic [DW-1:0] d);
    in_valid = 1'b1; in_vc = VCW'(v); in_data = d;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic gen_packet(input int v);
    int len;
    if ($urandom_range(15) == 0) begin
      src[v].push_back(mk(($urandom_range(1) == 0) ? T_BODY : T_TAIL, 0));
    end else begin
      len = $urandom_range(1, 4);
      if (len == 1) begin
        src[v].push_back(mk(T_SINGLE, $urandom_range(3)));
      end else begin
        src[v].push_back(mk(T_HEAD, $urandom_range(3)));
        for (int i = 0; i < len - 2; i++) src[v].push_back(mk(T_BODY, 0));
        src[v].push_back(mk(T_TAIL, 0));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its summary in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] hd, h1;
    int            seq [6];
    int            n_seq;

    rst = 1'b0;
    idle_inputs();
    model_reset();
    drive_fifo_outputs();

    // ---------------- reset state ----------------
    do_reset();
    check("reset_out_valid", last_ov, 1'b0);
    check("reset_err_count", last_err, 0);
    check("reset_route_req", last_req, 0);

    // ---------------- single packet on VC1 ----------------
    out_ready = 1'b1;
    hd = mk(T_HEAD, 2);
    push(1, hd);                                        // c0: head enters FIFO
    check("t1_c0_rqv", last_rqv, 4'b0000);
    push(1, mk(T_BODY, 0));                             // c1: head at front
    check("t1_c1_rqv", last_rqv, 4'b0000);
    route_grant = 4'b0010;
    push(1, mk(T_TAIL, 1));                             // c2: request visible
    check("t1_c2_rqv", last_rqv, 4'b0010);
    check("t1_c2_req", last_req[3:2], 2);
    check("t1_c2_ov", last_ov, 1'b0);
    route_grant = '0;
    cycle();                                            // c3: first flit out
    check("t1_c3_ov", last_ov, 1'b1);
    check("t1_c3_vc", last_vc, 1);
    check("t1_c3_data", last_data, hd);
    check("t1_c3_pop", last_pop, 4'b0010);
    cycle();                                            // c4: body
    check("t1_c4_vc", last_vc, 1);
    cycle();                                            // c5: tail
    check("t1_c5_vc", last_vc, 1);
    check("t1_c5_rel", last_rel, 4'b0000);
    cycle();                                            // c6: release pulse
    check("t1_c6_rel", last_rel, 4'b0010);
    check("t1_c6_ov", last_ov, 1'b0);
    cycle();
    check("t1_c7_rel", last_rel, 4'b0000);
    check("t1_c7_rqv", last_rqv, 4'b0000);

    // ---------------- round robin VC0 / VC2 ----------------
    do_reset();
    route_grant = 4'b0101;
    push(0, mk(T_HEAD, 1)); push(2, mk(T_HEAD, 3));
    push(0, mk(T_BODY, 0)); push(2, mk(T_BODY, 0));
    push(0, mk(T_TAIL, 0)); push(2, mk(T_TAIL, 0));
    for (int i = 0; i < 3; i++) cycle();
    route_grant = '0;
    out_ready = 1'b1;
    n_seq = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (last_ov) begin
        seq[n_seq] = int'(last_vc);
        n_seq++;
      end
    end
    check("rr_count", n_seq, 6);
    for (int i = 0; i < 6; i++) check("rr_seq", (i < n_seq) ? seq[i] : -1, (i % 2 == 0) ? 0 : 2);

    // ---------------- backpressure ----------------
    do_reset();
    route_grant = 4'b0011;
    push(0, mk(T_HEAD, 0));
    h1 = mk(T_HEAD, 1);
    push(1, h1);
    push(0, mk(T_BODY, 0)); push(1, mk(T_BODY, 0));
    push(0, mk(T_BODY, 0)); push(1, mk(T_TAIL, 0));
    push(0, mk(T_TAIL, 0));
    for (int i = 0; i < 3; i++) cycle();
    out_ready = 1'b1;
    cycle();
    check("bp_first_vc", last_vc, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_stall_vc", last_vc, 1);
      check("bp_stall_data", last_data, h1);
      check("bp_stall_pop", last_pop, 4'b0000);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_resume_vc", last_vc, 1);
    check("bp_resume_pop", last_pop, 4'b0010);

    // ---------------- orphan drop ----------------
    do_reset();
    push(3, mk(T_BODY, 0));
    cycle();
    check("orphan_pop", last_pop, 4'b1000);
    check("orphan_rqv", last_rqv, 4'b0000);
    check("orphan_err_before", last_err, 0);
    cycle();
    check("orphan_err_after", last_err, 1);
    check("orphan_pop_after", last_pop, 4'b0000);

    // ---------------- error counter saturation ----------------
    do_reset();
    in_valid = 1'b1; in_vc = 2'd3;
    for (int i = 0; i < 302; i++) begin
      in_data = mk(T_TAIL, 0);
      cycle();
    end
    in_valid = 1'b0;
    cycle(); cycle();
    check("sat_err", last_err, 255);

    // ---------------- reset mid-packet ----------------
    do_reset();
    route_grant = 4'b0001;
    push(0, mk(T_HEAD, 3));
    push(0, mk(T_BODY, 0));
    for (int i = 0; i < 3; i++) cycle();
    check("mid_active_ov", last_ov, 1'b1);
    route_grant = '0;
    rst = 1'b0;                      // FIFO contents kept across this reset
    cycle();
    check("mid_rst_ov", last_ov, 1'b0);
    check("mid_rst_pop", last_pop, 4'b0000);
    check("mid_rst_rel", last_rel, 4'b0000);
    cycle();
    rst = 1'b1;
    cycle();
    check("mid_post_rel", last_rel, 4'b0000);
    cycle();
    check("mid_rerequest", last_rqv, 4'b0001);
    check("mid_rerequest_req", last_req[1:0], 3);

    // ---------------- randomized traffic ----------------
    do_reset();
    n_out = 0;
    for (int c = 0; c < 3000; c++) begin
      int v;
      v = $urandom_range(VC - 1);
      if (src[v].size() == 0) gen_packet(v);
      in_vc    = VCW'(v);
      in_valid = ($urandom_range(3) != 0);
      in_data  = src[v][0];
      for (int g = 0; g < VC; g++) route_grant[g] = ($urandom_range(2) == 0);
      out_ready = ($urandom_range(3) != 0);
      cycle();
      if (last_push[v]) void'(src[v].pop_front());
    end
    check("rand_progress", (n_out > 200) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
